// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared defaults and last-winner encoding for mem_port_arbiter
package mem_port_arbiter_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_BURST_MAX = 8;

    typedef enum logic {
        LAST_CPU  = 1'b0,
        LAST_DISP = 1'b1
    } arb_state_e;

    // Burst counter must hold BURST_MAX and is never narrower than 4 bits.
    function automatic int burst_cnt_width(input int burst_max);
        int w;
        w = $clog2(burst_max + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb2_core.sv
// rtl/mem_port_arbiter_arb2_core.sv - two-way grant logic with last-winner state and display burst limit
module arb2_core
    import mem_port_arbiter_pkg::*;
#(
    parameter int BURST_MAX = DEFAULT_BURST_MAX,
    parameter bit RR_EN     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req_i,
    input  logic disp_req_i,
    output logic cpu_gnt_o,
    output logic disp_gnt_o
);

    localparam int CW = burst_cnt_width(BURST_MAX);

    arb_state_e    state_q;
    logic [CW-1:0] burst_q;
    logic          burst_full;
    logic          disp_turn;

    assign burst_full = (burst_q >= CW'(BURST_MAX));
    // Display only wins contention when rotating away from a CPU win and its burst budget remains.
    assign disp_turn  = RR_EN && (state_q == LAST_CPU) && !burst_full;

    always_comb begin
        cpu_gnt_o  = 1'b0;
        disp_gnt_o = 1'b0;
        if (!reset) begin
            if (cpu_req_i && (!disp_req_i || !disp_turn)) begin
                cpu_gnt_o = 1'b1;
            end else if (disp_req_i) begin
                disp_gnt_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LAST_DISP;
            burst_q <= '0;
        end else begin
            if (cpu_gnt_o) begin
                state_q <= LAST_CPU;
            end else if (disp_gnt_o) begin
                state_q <= LAST_DISP;
            end
            if (disp_gnt_o) begin
                burst_q <= burst_full ? burst_q : burst_q + 1'b1;
            end else begin
                burst_q <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/display arbiter for memory port B; MEM_ARB_ROUND_ROBIN_EN selects round-robin
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int BURST_MAX = DEFAULT_BURST_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             disp_req,
    input  logic [WIDTH-1:0] disp_addr,
    output logic             disp_gnt,
    output logic             disp_rvalid,
    output logic [WIDTH-1:0] disp_rdata,
    output logic             mem_we_b,
    output logic [WIDTH-1:0] mem_addr_b,
    output logic [WIDTH-1:0] mem_data_b,
    input  logic [WIDTH-1:0] mem_q_b
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic             cpu_pend_q;
    logic             disp_pend_q;
    logic [WIDTH-1:0] cpu_hold_q;
    logic [WIDTH-1:0] disp_hold_q;

    arb2_core #(
        .BURST_MAX (BURST_MAX),
        .RR_EN     (RR_EN)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .cpu_req_i  (cpu_req),
        .disp_req_i (disp_req),
        .cpu_gnt_o  (cpu_gnt),
        .disp_gnt_o (disp_gnt)
    );

    always_comb begin
        mem_we_b   = 1'b0;
        mem_addr_b = '0;
        mem_data_b = '0;
        if (cpu_gnt) begin
            mem_we_b   = cpu_we;
            mem_addr_b = cpu_addr;
            mem_data_b = cpu_wdata;
        end else if (disp_gnt) begin
            mem_addr_b = disp_addr;
        end
    end

    // mem_q_b arrives the cycle after the grant, so it is forwarded live and latched for holding.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_pend_q  <= 1'b0;
            disp_pend_q <= 1'b0;
            cpu_hold_q  <= '0;
            disp_hold_q <= '0;
        end else begin
            cpu_pend_q  <= cpu_gnt;
            disp_pend_q <= disp_gnt;
            if (cpu_pend_q) begin
                cpu_hold_q <= mem_q_b;
            end
            if (disp_pend_q) begin
                disp_hold_q <= mem_q_b;
            end
        end
    end

    assign cpu_rvalid  = cpu_pend_q && !reset;
    assign disp_rvalid = disp_pend_q && !reset;
    assign cpu_rdata   = reset ? '0 : (cpu_pend_q ? mem_q_b : cpu_hold_q);
    assign disp_rdata  = reset ? '0 : (disp_pend_q ? mem_q_b : disp_hold_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with behavioural reference model
module tb_mem_port_arbiter;

    localparam int BMAX = 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [15:0] cwdata;
        logic        dreq;
        logic [15:0] daddr;
        logic        ecg;
        logic        edg;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, disp_req;
    logic [15:0] cpu_addr, cpu_wdata, disp_addr;
    logic        cpu_gnt, cpu_rvalid, disp_gnt, disp_rvalid, mem_we_b;
    logic [15:0] cpu_rdata, disp_rdata, mem_addr_b, mem_data_b, mem_q_b;

    logic [15:0] mem    [256];
    logic [15:0] shadow [256];

    int checks = 0;
    int errors = 0;

    bit          m_last_cpu;
    int          m_streak;
    bit          m_pc, m_pd;
    logic [15:0] m_pcd, m_pdd, m_hc, m_hd;
    bit          last_cg, last_dg, dut_cg;

    mem_port_arbiter #(.WIDTH(16), .BURST_MAX(BMAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b),
        .mem_q_b(mem_q_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we_b) mem[mem_addr_b[7:0]] <= mem_data_b;
        mem_q_b <= mem_we_b ? mem_data_b : mem[mem_addr_b[7:0]];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic creq, input logic cwe,
                                input logic [15:0] caddr, input logic [15:0] cwdata,
                                input logic dreq, input logic [15:0] daddr,
                                input logic ecg, input logic edg);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
        v.dreq = dreq; v.daddr = daddr; v.ecg = ecg; v.edg = edg;
        return v;
    endfunction

    task automatic step(input vec_t v, input bit use_exp);
        bit m_cg, m_dg;
        reset = v.rst; cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr;
        cpu_wdata = v.cwdata; disp_req = v.dreq; disp_addr = v.daddr;
        #3;
        m_cg = 1'b0; m_dg = 1'b0;
        if (!v.rst) begin
            if (v.creq && v.dreq) begin
                if (RR && m_last_cpu && m_streak < BMAX) m_dg = 1'b1;
                else m_cg = 1'b1;
            end else begin
                m_cg = v.creq;
                m_dg = v.dreq;
            end
        end
        chk("cpu_gnt", 16'(cpu_gnt), 16'(m_cg));
        chk("disp_gnt", 16'(disp_gnt), 16'(m_dg));
        if (use_exp) begin
            chk("tbl_cpu_gnt", 16'(cpu_gnt), 16'(v.ecg));
            chk("tbl_disp_gnt", 16'(disp_gnt), 16'(v.edg));
        end
        chk("mem_we_b", 16'(mem_we_b), 16'(m_cg && v.cwe));
        chk("mem_addr_b", mem_addr_b, m_cg ? v.caddr : (m_dg ? v.daddr : 16'h0));
        chk("mem_data_b", mem_data_b, m_cg ? v.cwdata : 16'h0);
        chk("cpu_rvalid", 16'(cpu_rvalid), 16'(!v.rst && m_pc));
        chk("cpu_rdata", cpu_rdata, v.rst ? 16'h0 : (m_pc ? m_pcd : m_hc));
        chk("disp_rvalid", 16'(disp_rvalid), 16'(!v.rst && m_pd));
        chk("disp_rdata", disp_rdata, v.rst ? 16'h0 : (m_pd ? m_pdd : m_hd));
        dut_cg  = cpu_gnt;
        last_cg = m_cg;
        last_dg = m_dg;
        @(posedge clk);
        if (v.rst) begin
            m_last_cpu = 1'b0; m_streak = 0; m_pc = 1'b0; m_pd = 1'b0;
            m_hc = '0; m_hd = '0;
        end else begin
            if (m_pc) m_hc = m_pcd;
            if (m_pd) m_hd = m_pdd;
            m_pc = m_cg;
            m_pd = m_dg;
            if (m_cg) begin
                m_pcd = v.cwe ? v.cwdata : shadow[v.caddr[7:0]];
                if (v.cwe) shadow[v.caddr[7:0]] = v.cwdata;
                m_last_cpu = 1'b1;
            end
            if (m_dg) begin
                m_pdd = shadow[v.daddr[7:0]];
                m_last_cpu = 1'b0;
                m_streak++;
            end else begin
                m_streak = 0;
            end
        end
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   beats;
        bit   cpu_seen;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        m_last_cpu = 1'b0; m_streak = 0; m_pc = 1'b0; m_pd = 1'b0;
        m_pcd = '0; m_pdd = '0; m_hc = '0; m_hd = '0;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        disp_req = 1'b0; disp_addr = '0;
        @(posedge clk); #1;

        tbl.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 1, 16'h0100, 0, 0));
        tbl.push_back(mk(1, 1, 1, 16'h0010, 16'h5555, 1, 16'h0100, 0, 0));
        tbl.push_back(mk(0, 1, 1, 16'h0010, 16'h1234, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 1, 16'h0100 + 16'(i), 16'hA100 + 16'(i), 0, 16'h0000, 1, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0100 + 16'(i), 0, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 0, 16'h0010, 16'h0000, 1, 16'h0101, !(RR && i % 2 == 1), RR && i % 2 == 1));
        tbl.push_back(mk(0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0010, 16'h0000, 1, 16'h0102, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0103, 16'h0000, 1, 16'h0102, 1, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 1, 0, 16'h0101, 16'h0000, 1, 16'h0102, !(RR && i % 2 == 1), RR && i % 2 == 1));
        foreach (tbl[i]) step(tbl[i], 1'b1);

        // Display streams alone, then the CPU joins and must break in within BMAX beats.
        step(mk(1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 0), 1'b0);
        beats = 0; cpu_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(mk(0, i >= 3, 0, 16'h0103, 16'h0, 1, 16'h0100 + 16'(i % 4), 0, 0), 1'b0);
            if (i >= 3 && !cpu_seen) begin
                if (dut_cg) cpu_seen = 1'b1;
                else beats++;
            end
        end
        chk("burst_cpu_seen", 16'(cpu_seen), 16'h1);
        checks++;
        if (beats > BMAX) begin
            errors++;
            $display("FAIL burst_beats: got %0d expected at most %0d", beats, BMAX);
        end

        v = mk(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            bit rst_now;
            rst_now = ($urandom_range(0, 39) == 0);
            if (v.rst || !(v.creq && !last_cg)) begin
                v.creq   = ($urandom_range(0, 9) < 6);
                v.cwe    = $urandom_range(0, 1);
                v.caddr  = 16'($urandom);
                v.cwdata = 16'($urandom);
            end
            if (v.rst || !(v.dreq && !last_dg)) begin
                v.dreq  = ($urandom_range(0, 9) < 6);
                v.daddr = 16'($urandom);
            end
            v.rst = rst_now;
            step(v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
